// File: rtl/matrix_framebuf_if.sv
// Write port of matrix_framebuf: game logic pushes one pixel per accepted valid/ready beat.
interface matrix_framebuf_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [5:0] wr_x;
  logic [4:0] wr_y;
  logic [2:0] wr_rgb;

  modport master (output wr_valid, output wr_x, output wr_y, output wr_rgb, input wr_ready);
  modport slave  (input wr_valid, input wr_x, input wr_y, input wr_rgb, output wr_ready);
endinterface

// File: rtl/matrix_framebuf.sv
// Double-buffered 64x32 RGB frame store with tear-free swap at the panel frame boundary.
// Define FB_CLEAR_EN to build the back-bank clear engine (CLEAR state, clr_busy).
module matrix_framebuf #(
  parameter int unsigned W_COL = 7,
  parameter int unsigned W_ROW = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [W_COL-1:0]   rd_col,
  input  logic [W_ROW-1:0]   rd_row,
  output logic               R0,
  output logic               G0,
  output logic               B0,
  output logic               R1,
  output logic               G1,
  output logic               B1,
  matrix_framebuf_if.slave   wr,
  input  logic               frame_done,
  output logic               swap_done,
  input  logic               clr_req,
  output logic               clr_busy
);

  localparam int unsigned AW    = 10;
  localparam int unsigned DEPTH = 2 * (1 << AW);

`ifdef FB_CLEAR_EN
  typedef enum logic [1:0] {IDLE, CLEAR, WAIT_SWAP} state_t;
`else
  typedef enum logic {IDLE, WAIT_SWAP} state_t;
`endif

  state_t            state_q, state_d;
  logic              bank_sel_q, bank_sel_d;
  logic              swap_done_q, swap_done_d;
  logic [W_ROW-1:0]  prev_row_q, prev_row_d;
  logic [2:0]        up_q, up_d;
  logic [2:0]        lo_q, lo_d;

  // Bank is the MSB of the index: {bank, y[3:0], x[5:0]}
  logic [2:0]        mem_up [DEPTH];
  logic [2:0]        mem_lo [DEPTH];
  logic              mem_we_up, mem_we_lo;
  logic [AW-1:0]     mem_waddr;
  logic [2:0]        mem_wdata;
  logic [AW:0]       rd_addr;
  logic              rd_blank;

`ifdef FB_CLEAR_EN
  logic [AW-1:0]     clr_addr_q, clr_addr_d;
  logic              clr_busy_q, clr_busy_d;
`endif

  assign rd_addr  = {bank_sel_q, 4'(rd_row), 6'(rd_col)};
  assign rd_blank = (rd_col > W_COL'(63));

  assign wr.wr_ready = (state_q == IDLE);

  always_comb begin
    state_d     = state_q;
    bank_sel_d  = bank_sel_q;
    swap_done_d = 1'b0;
    prev_row_d  = rd_row;
    mem_we_up   = 1'b0;
    mem_we_lo   = 1'b0;
    mem_waddr   = {wr.wr_y[3:0], wr.wr_x};
    mem_wdata   = wr.wr_rgb;
    up_d        = rd_blank ? 3'b000 : mem_up[rd_addr];
    lo_d        = rd_blank ? 3'b000 : mem_lo[rd_addr];
`ifdef FB_CLEAR_EN
    clr_addr_d  = clr_addr_q;
`endif

    case (state_q)
      IDLE: begin
        if (wr.wr_valid) begin
          mem_we_up = ~wr.wr_y[4];
          mem_we_lo = wr.wr_y[4];
        end
        // frame_done has priority; a simultaneous clr_req is dropped
        if (frame_done) begin
          state_d = WAIT_SWAP;
        end
`ifdef FB_CLEAR_EN
        else if (clr_req) begin
          state_d    = CLEAR;
          clr_addr_d = '0;
        end
`endif
      end
`ifdef FB_CLEAR_EN
      CLEAR: begin
        mem_we_up  = 1'b1;
        mem_we_lo  = 1'b1;
        mem_waddr  = clr_addr_q;
        mem_wdata  = 3'b000;
        clr_addr_d = clr_addr_q + AW'(1);
        if (clr_addr_q == '1) begin
          state_d = IDLE;
        end
      end
`endif
      WAIT_SWAP: begin
        if ((prev_row_q == W_ROW'(15)) && (rd_row == '0)) begin
          bank_sel_d  = ~bank_sel_q;
          swap_done_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef FB_CLEAR_EN
    clr_busy_d = (state_d == CLEAR);
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      bank_sel_q  <= 1'b0;
      swap_done_q <= 1'b0;
      prev_row_q  <= '0;
      up_q        <= 3'b000;
      lo_q        <= 3'b000;
    end else begin
      state_q     <= state_d;
      bank_sel_q  <= bank_sel_d;
      swap_done_q <= swap_done_d;
      prev_row_q  <= prev_row_d;
      up_q        <= up_d;
      lo_q        <= lo_d;
    end
  end

`ifdef FB_CLEAR_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clr_addr_q <= '0;
      clr_busy_q <= 1'b0;
    end else begin
      clr_addr_q <= clr_addr_d;
      clr_busy_q <= clr_busy_d;
    end
  end
  assign clr_busy = clr_busy_q;
`else
  logic unused_clr_req;
  assign unused_clr_req = clr_req;
  assign clr_busy       = 1'b0;
`endif

  // Writes and clears only ever target the back bank
  always_ff @(posedge clk) begin
    if (mem_we_up) mem_up[{~bank_sel_q, mem_waddr}] <= mem_wdata;
    if (mem_we_lo) mem_lo[{~bank_sel_q, mem_waddr}] <= mem_wdata;
  end

  assign {R0, G0, B0} = up_q;
  assign {R1, G1, B1} = lo_q;
  assign swap_done    = swap_done_q;

endmodule

// File: tb/tb_matrix_framebuf.sv
// Randomized scoreboard bench for matrix_framebuf against a pixel-level (x,y) model.
module tb_matrix_framebuf;

`ifdef FB_CLEAR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif
  localparam int M_IDLE = 0, M_CLR = 1, M_WAIT = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] rd_col = '0;
  logic [3:0] rd_row = '0;
  logic       frame_done = 1'b0;
  logic       clr_req = 1'b0;
  logic       R0, G0, B0, R1, G1, B1;
  logic       swap_done, clr_busy;

  matrix_framebuf_if wr_if ();

  matrix_framebuf #(.W_COL(7), .W_ROW(4)) dut (
    .clk(clk), .rst(rst), .rd_col(rd_col), .rd_row(rd_row),
    .R0(R0), .G0(G0), .B0(B0), .R1(R1), .G1(G1), .B1(B1),
    .wr(wr_if), .frame_done(frame_done), .swap_done(swap_done),
    .clr_req(clr_req), .clr_busy(clr_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] up;
    logic [2:0] lo;
    bit         swp;
    bit         rdy;
    bit         busy;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Reference: whole-panel picture per bank, indexed by screen y (0..31) and x
  logic [2:0] m [2][32][64];
  int         sel, mode, prev, caddr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    foreach (m[b, y, x]) m[b][y][x] = 3'bxxx;
    sel = 0; mode = M_IDLE; prev = 0; caddr = 0;
  end

  always @(posedge clk) begin : model
    exp_t e;
    int   back;
    if (!rst) begin
      sel = 0; mode = M_IDLE; prev = 0;
    end else begin
      if (rd_col >= 7'd64) begin
        e.up = 3'b000; e.lo = 3'b000;
      end else begin
        e.up = m[sel][int'(rd_row)][int'(rd_col[5:0])];
        e.lo = m[sel][int'(rd_row) + 16][int'(rd_col[5:0])];
      end
      e.swp = 1'b0;
      back  = 1 - sel;
      if (mode == M_IDLE) begin
        if (wr_if.wr_valid) m[back][int'(wr_if.wr_y)][int'(wr_if.wr_x)] = wr_if.wr_rgb;
        if (frame_done) mode = M_WAIT;
        else if (CLR_EN && clr_req) begin mode = M_CLR; caddr = 0; end
      end else if (mode == M_CLR) begin
        m[back][caddr / 64][caddr % 64]      = 3'b000;
        m[back][caddr / 64 + 16][caddr % 64] = 3'b000;
        if (caddr == 1023) mode = M_IDLE;
        caddr++;
      end else begin
        if (prev == 15 && rd_row == 4'd0) begin
          sel = 1 - sel; e.swp = 1'b1; mode = M_IDLE;
        end
      end
      prev   = int'(rd_row);
      e.rdy  = (mode == M_IDLE);
      e.busy = (mode == M_CLR);
      sb.push_back(e);
    end
  end

  always @(posedge clk) begin : monitor
    exp_t e;
    #2;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (!$isunknown(e.up)) chk("pix_upper", 32'({R0, G0, B0}), 32'(e.up));
      if (!$isunknown(e.lo)) chk("pix_lower", 32'({R1, G1, B1}), 32'(e.lo));
      chk("swap_done", 32'(swap_done), 32'(e.swp));
      chk("wr_ready", 32'(wr_if.wr_ready), 32'(e.rdy));
      chk("clr_busy", 32'(clr_busy), 32'(e.busy));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic quiet();
    wr_if.wr_valid = 1'b0; frame_done = 1'b0; clr_req = 1'b0;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_rgb"}, 32'({R0, G0, B0, R1, G1, B1}), 32'd0);
    chk({tag, "_wr_ready"}, 32'(wr_if.wr_ready), 32'd1);
    chk({tag, "_swap_done"}, 32'(swap_done), 32'd0);
    chk({tag, "_clr_busy"}, 32'(clr_busy), 32'd0);
  endtask

  task automatic write_px(input int x, input int y, input logic [2:0] rgb);
    wr_if.wr_valid = 1'b1; wr_if.wr_x = 6'(x); wr_if.wr_y = 5'(y); wr_if.wr_rgb = rgb;
    tick();
    wr_if.wr_valid = 1'b0;
  endtask

  task automatic fill_back();
    for (int y = 0; y < 32; y++)
      for (int x = 0; x < 64; x++) begin
        rd_col = 7'($urandom_range(0, 70)); rd_row = 4'($urandom);
        write_px(x, y, 3'($urandom));
      end
  endtask

  task automatic do_swap();
    frame_done = 1'b1; rd_row = 4'd1; tick();
    frame_done = 1'b0; rd_row = 4'd15; tick();
    rd_row = 4'd0; tick();
    chk("swap_at_boundary", 32'(swap_done), 32'd1);
  endtask

  initial begin : driver
    int cnt, rowcnt;
    quiet();
    wr_if.wr_x = '0; wr_if.wr_y = '0; wr_if.wr_rgb = '0;
    repeat (3) tick();
    reset_checks("reset");
    rst = 1'b1;
    tick();

    fill_back(); do_swap();
    fill_back(); do_swap();

`ifdef FB_CLEAR_EN
    clr_req = 1'b1; tick(); clr_req = 1'b0;
    cnt = 0;
    for (int i = 0; i < 1100; i++) begin
      if (clr_busy) cnt++;
      if (clr_busy && wr_if.wr_ready) chk("ready_during_clear", 32'(wr_if.wr_ready), 32'd0);
      wr_if.wr_valid = 1'($urandom); wr_if.wr_x = 6'($urandom); wr_if.wr_y = 5'($urandom);
      wr_if.wr_rgb = 3'($urandom); rd_col = 7'($urandom_range(0, 70)); rd_row = 4'($urandom);
      tick();
    end
    wr_if.wr_valid = 1'b0;
    chk("clear_cycles", 32'(cnt), 32'd1024);
`else
    clr_req = 1'b1; tick(); clr_req = 1'b0;
    chk("noclr_busy", 32'(clr_busy), 32'd0);
    chk("noclr_ready", 32'(wr_if.wr_ready), 32'd1);
    tick();
`endif

    write_px(5, 3, 3'b100);
    write_px(5, 19, 3'b011);
    do_swap();
    rd_row = 4'd3; rd_col = 7'd5; tick();
    chk("readback_upper", 32'({R0, G0, B0}), 32'b100);
    chk("readback_lower", 32'({R1, G1, B1}), 32'b011);

    rd_col = 7'd64; rd_row = 4'd9; tick();
    chk("blank_col64", 32'({R0, G0, B0, R1, G1, B1}), 32'd0);

    // Pending swap must wait out a stalled row and block writes
    frame_done = 1'b1; rd_row = 4'd1; tick(); frame_done = 1'b0;
    rd_row = 4'd7;
    repeat (500) begin
      wr_if.wr_valid = 1'b1; wr_if.wr_x = 6'($urandom); wr_if.wr_y = 5'($urandom);
      wr_if.wr_rgb = 3'($urandom); rd_col = 7'($urandom_range(0, 70)); tick();
    end
    chk("hold_ready_low", 32'(wr_if.wr_ready), 32'd0);
    chk("hold_no_swap", 32'(swap_done), 32'd0);
    wr_if.wr_valid = 1'b0;
    rd_row = 4'd15; tick();
    rd_row = 4'd0; tick();
    chk("hold_swap", 32'(swap_done), 32'd1);

    // frame_done + clr_req + write together
    frame_done = 1'b1; clr_req = 1'b1; rd_row = 4'd2;
    write_px(9, 20, 3'b101);
    quiet();
    chk("simul_clr_busy", 32'(clr_busy), 32'd0);
    chk("simul_wait", 32'(wr_if.wr_ready), 32'd0);
    rd_row = 4'd15; tick();
    rd_row = 4'd0; tick();
    chk("simul_swap", 32'(swap_done), 32'd1);
    rd_row = 4'd4; rd_col = 7'd9; tick();
    chk("simul_write_visible", 32'({R1, G1, B1}), 32'b101);

    rowcnt = 1;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        quiet(); rst = 1'b0; tick(); tick();
        reset_checks("midreset");
        rst = 1'b1;
      end
      wr_if.wr_valid = 1'($urandom); wr_if.wr_x = 6'($urandom); wr_if.wr_y = 5'($urandom);
      wr_if.wr_rgb = 3'($urandom);
      frame_done = ($urandom_range(0, 39) == 0);
      clr_req    = ($urandom_range(0, 399) == 0);
      rd_col     = 7'($urandom_range(0, 70));
      rowcnt--;
      if (rowcnt == 0) begin rd_row = rd_row + 4'd1; rowcnt = $urandom_range(1, 4); end
      tick();
    end
    quiet();
    repeat (3) tick();
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/matrix_framebuf.md
# matrix_framebuf

Double-buffered pixel store for the 64×32 LED matrix panel. Answers the scan driver's column/row requests with upper-half and lower-half RGB bits (`R0..B1`). The game logic draws into a hidden back bank through a valid/ready write port. A requested bank swap takes effect only at the panel's frame boundary, so a frame never tears. An optional clear engine zeroes the back bank.

## Interface
- `W_COL`, default 7, width of the driver column request (values 0..64).
- `W_ROW`, default 4, width of the driver row request (values 0..15).
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `rd_col` in W_COL: driver column request; pixel x = `rd_col[5:0]`; values ≥ 64 select blank.
- `rd_row` in W_ROW: driver row request; upper pixel y = `rd_row`, lower pixel y = `rd_row + 16`.
- `R0`,`G0`,`B0` out 1 each: upper-half pixel, registered.
- `R1`,`G1`,`B1` out 1 each: lower-half pixel, registered.
- `wr_valid` in 1: write request.
- `wr_ready` out 1: write port accepts this cycle.
- `wr_x` in 6: pixel x, 0..63.
- `wr_y` in 5: pixel y, 0..31; `wr_y[4]` selects the lower half.
- `wr_rgb` in 3: {R,G,B}.
- `frame_done` in 1: single-cycle pulse; back bank complete, request swap.
- `swap_done` out 1: single-cycle pulse when the swap takes effect.
- `clr_req` in 1: single-cycle pulse; clear back bank.
- `clr_busy` out 1: high while clearing.

## Operation
- Storage is two banks. Each bank holds an upper array and a lower array of 1024×3 bits, addressed `{y[3:0], x[5:0]}`. `front` = `bank_sel`, `back` = `~bank_sel`. `bank_sel` resets to 0. Memory contents are not reset.
- Read path: each cycle, read the front bank upper and lower arrays at `{rd_row, rd_col[5:0]}` and register the result into `R0..B1`. If `rd_col ≥ 64`, register all zeros.
- The read path runs continuously in every FSM state. The write and clear paths touch only the back bank.
- The FSM has three states: IDLE, CLEAR, WAIT_SWAP. It resets to IDLE.
- IDLE:
  - `wr_ready` = 1.
  - On `wr_valid`, write `wr_rgb` into the back bank at `{wr_y[3:0], wr_x}`. Use the lower array if `wr_y[4]`, else the upper array.
  - On `frame_done`, go to WAIT_SWAP.
  - Else on `clr_req`, go to CLEAR and set `clr_addr` = 0.
- CLEAR:
  - `wr_ready` = 0, `clr_busy` = 1.
  - Each cycle, write 0 to both back-bank arrays at `clr_addr` and increment `clr_addr` (10 bits).
  - After writing 1023, go to IDLE. Total 1024 cycles.
- WAIT_SWAP:
  - `wr_ready` = 0.
  - Frame boundary = registered `prev_row` == 15 and `rd_row` == 0. `prev_row` resets to 0.
  - On the boundary: toggle `bank_sel`, pulse `swap_done` for one cycle, go to IDLE.
- Simultaneous events:
  - A write and `frame_done` in the same IDLE cycle: the write is performed, then the FSM goes to WAIT_SWAP.
  - `frame_done` and `clr_req` in the same cycle: `frame_done` wins and `clr_req` is dropped.
  - `clr_req` or `frame_done` outside IDLE: ignored.
- Reset mid-operation: FSM returns to IDLE, `bank_sel` = 0, any clear or pending swap is abandoned. Partially cleared memory is left as is.

## Timing
- Read latency is 1 cycle: request at edge N, `R0..B1` valid after edge N+1. The driver's own input register adds a second cycle downstream.
- A write is accepted on the edge where `wr_valid & wr_ready`. It becomes visible on `R0..B1` only after the next swap.
- `wr_ready` is decoded combinationally from the state. It is 1 from the first cycle after reset release.
- `swap_done` is high on the same cycle that the new `bank_sel` first drives the read address.
- Reset values: `R0..B1` = 0, `swap_done` = 0, `clr_busy` = 0, `wr_ready` = 1 (IDLE).
- Worst-case swap wait is one full panel frame: 16 rows × the driver row period.

## Configuration
- `FB_CLEAR_EN` defined: the clear engine and the CLEAR state are built as described.
- `FB_CLEAR_EN` undefined:
  - `clr_req` is ignored and `clr_busy` is tied to 0.
  - The FSM has only IDLE and WAIT_SWAP.
  - All ports remain present.

## Test plan
- Reset, then hold `rst` low mid-stream → all RGB outputs 0, `wr_ready` = 1, `swap_done` = 0, `bank_sel` = 0 after release.
- Clear back bank (`clr_req`) → `clr_busy` high for exactly 1024 cycles and `wr_ready` = 0 throughout. Then write (x=5, y=3, rgb=3'b100) and (x=5, y=19, rgb=3'b011). Pulse `frame_done` and step `rd_row` 15→0 → `swap_done` pulses once. Then `rd_row` = 3, `rd_col` = 5 → next cycle {R0,G0,B0} = 100 and {R1,G1,B1} = 011.
- `rd_col` = 64 at any row → all six outputs 0 one cycle later.
- After `frame_done`, hold `rd_row` = 7 for 500 cycles → no swap, `wr_ready` = 0, writes with `wr_valid` = 1 are not performed. Step the rows to 15 then 0 → swap occurs on that cycle.
- `frame_done` and `clr_req` asserted in the same cycle → FSM enters WAIT_SWAP and `clr_busy` stays 0. A write with `wr_valid` in that same cycle lands in the old back bank and is visible after the swap.
- Build without `FB_CLEAR_EN`: pulse `clr_req` → `clr_busy` stays 0 and `wr_ready` stays 1.
